puc_train_unit: RTL and testbench
=================================

# puc_train_unit

Training and recovery stage for the uncache (PUC) predictor. Fetch records each issued PC and its predicted uncache bit in order. When address translation resolves the real attribute, the unit compares it with the prediction. On a mismatch it issues the predictor write bus and a refetch redirect. It sits between the IF translation/response path and the PUC predictor's `wbus_i`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: in-flight fetch records, power of 2.
- `IDX_LSB`, 12: low PC bit of the predictor index.
- `IDX_W`, 5: predictor index width; equals `PucAddrWidth`.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid_i`  in  1  fetch issued a PC.
- `req_ready_o`  out  1  record accepted.
- `req_pc_i`  in  32  issued PC.
- `req_pred_uc_i`  in  1  predictor output used for this fetch.
- `rsp_valid_i`  in  1  translation result for the oldest record.
- `rsp_ready_o`  out  1  result consumed.
- `rsp_uc_i`  in  1  actual uncache attribute.
- `flush_i`  in  1  backend flush.
- `puc_wbus_o`  out  `IDX_W+2`  `{we, waddr, wdata}`, to predictor `wbus_i`.
- `redirect_valid_o`  out  1  refetch request.
- `redirect_pc_o`  out  32  PC to refetch.
- `redirect_ack_i`  in  1  fetch accepted the redirect.
- `resolve_cnt_o`  out  `CNT_W`  resolved records.
- `mispred_cnt_o`  out  `CNT_W`  mispredictions.

## Operation
State machine states: IDLE, REDIRECT.

Handshakes:
- Push: occurs when `req_valid_i & req_ready_o`; stores `{pc, pred}`.
- `req_ready_o` = state==IDLE & !full. It stays 0 when full, even if a pop occurs in the same cycle.
- Pop: occurs when `rsp_valid_i & rsp_ready_o`.
- `rsp_ready_o` = state==IDLE & !empty. A `rsp_valid_i` seen while empty is ignored and no error is raised.

On a pop:
- `resolve_cnt_o` increments.
- If `rsp_uc_i == pred`, nothing else happens.
- If `rsp_uc_i != pred`:
  - `mispred_cnt_o` increments.
  - `puc_wbus_o` pulses `{1, pc[IDX_LSB+IDX_W-1:IDX_LSB], rsp_uc_i}`.
  - `redirect_pc_o` is set to pc.
  - The state goes to REDIRECT.

In REDIRECT:
- `redirect_valid_o`=1 and `redirect_pc_o` is held stable.
- On `redirect_ack_i`, the FIFO is cleared, because all younger records are wrong-path. The state returns to IDLE.

`flush_i` behaviour:
- In any state, the FIFO is cleared and the state goes to IDLE.
- It has priority over push, pop and ack in the same cycle.
- Any pending redirect is dropped.
- A wbus pulse already scheduled is still emitted, since training is valid regardless of the flush.

Counters saturate at all-ones and never wrap.

Reset values:
- FIFO empty, state IDLE.
- `puc_wbus_o`=0, `redirect_valid_o`=0, `redirect_pc_o`=0.
- Both counters 0.
- `req_ready_o`=1; `rsp_ready_o`=0.

## Timing
- Push and pop can occur in the same cycle in IDLE; occupancy is unchanged.
- Mismatching pop in cycle T:
  - `puc_wbus_o.we`=1 for exactly cycle T+1, registered.
  - `redirect_valid_o`=1 from T+1 through the ack cycle inclusive; it is 0 the cycle after the ack.
  - `req_ready_o` and `rsp_ready_o` are 0 from T+1 until the state is back in IDLE.
- The predictor bypasses same-cycle writes, so a refetch issued at T+2 or later sees the corrected bit.
- `redirect_ack_i` in cycle T+1 is legal; the state is IDLE at T+2.
- Ack and flush in the same cycle: behaves as flush; the result is identical.
- Reset asserted mid-REDIRECT: all outputs return to reset values on the next edge; no wbus pulse is emitted.
- FIFO pointers are `log2(FIFO_DEPTH)+1` bits, with the wrap bit distinguishing full from empty.
- Counter increments use `CNT_W`-bit adds with an all-ones saturation check.

## Structure
Shared package/define file:
- `PucAddrWidth` (5) and `PucWbusWidth` (7).
- wbus field order `{we, waddr, wdata}`.
- `RstEnable` (1'b0).
- state encoding IDLE=0, REDIRECT=1.

Sub-module `puc_inflight_fifo`:
- Parameterised depth and width (33 bits).
- Sync clear, push/pop, full/empty.
- The top holds the FSM, compare logic, wbus register and counters.

## Test plan
- Reset held 2 cycles, then released → wbus=0, redirect_valid=0, counters 0, req_ready=1, rsp_ready=0.
- Push pc=0x1C00_0000 pred=1, then rsp uc=1 → no wbus pulse; resolve_cnt=1, mispred_cnt=0.
- Push pc=0x0000_5000 pred=1, then rsp uc=0 at T:
  - T+1: wbus=7'b1_00101_0; redirect_valid=1, pc=0x5000.
  - Ack at T+3 → IDLE at T+4; two younger pushes discarded (empty).
- Push 4 records with no rsp:
  - req_ready=0 on the 5th cycle; 5th PC retained by the source.
  - One pop → req_ready=1 the next cycle.
- Mismatch, then flush_i two cycles later with no ack → redirect_valid=0 the next cycle, FIFO empty, exactly one wbus pulse.
- With CNT_W=2, 5 mismatch resolutions each acked → mispred_cnt saturates at 3.

Source files
------------

// File: rtl/puc_train_unit_pkg.sv
// Shared types and constants for the PUC training/recovery stage.
package puc_train_unit_pkg;

    localparam int unsigned PucAddrWidth = 5;
    localparam int unsigned PucWbusWidth = PucAddrWidth + 2;

    // Value of rst_n that holds the block in reset.
    localparam logic RstEnable = 1'b0;

    // FSM encoding.
    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] REDIRECT = 1'b1;

    // Predictor write bus, MSB first: {we, waddr, wdata}.
    typedef struct packed {
        logic                    we;
        logic [PucAddrWidth-1:0] waddr;
        logic                    wdata;
    } puc_wbus_t;

endpackage

// File: rtl/puc_train_unit_if.sv
// Fetch-side record/response, flush, redirect, predictor write and counter bundle.
interface puc_train_unit_if
    import puc_train_unit_pkg::*;
#(
    parameter int unsigned IDX_W = PucAddrWidth,
    parameter int unsigned CNT_W = 32
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [31:0]      req_pc_i;
    logic             req_pred_uc_i;
    logic             rsp_valid_i;
    logic             rsp_ready_o;
    logic             rsp_uc_i;
    logic             flush_i;
    logic [IDX_W+1:0] puc_wbus_o;
    logic             redirect_valid_o;
    logic [31:0]      redirect_pc_o;
    logic             redirect_ack_i;
    logic [CNT_W-1:0] resolve_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;

    // Training unit side.
    modport slave (
        input  req_valid_i, req_pc_i, req_pred_uc_i, rsp_valid_i, rsp_uc_i,
               flush_i, redirect_ack_i,
        output req_ready_o, rsp_ready_o, puc_wbus_o, redirect_valid_o,
               redirect_pc_o, resolve_cnt_o, mispred_cnt_o
    );

    // Fetch / translation side.
    modport master (
        output req_valid_i, req_pc_i, req_pred_uc_i, rsp_valid_i, rsp_uc_i,
               flush_i, redirect_ack_i,
        input  req_ready_o, rsp_ready_o, puc_wbus_o, redirect_valid_o,
               redirect_pc_o, resolve_cnt_o, mispred_cnt_o
    );
endinterface

// File: rtl/puc_inflight_fifo.sv
// In-order FIFO of issued fetch records awaiting their translation result.
module puc_inflight_fifo
    import puc_train_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned PTR_W = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [PTR_W-1:0] count_o
);
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    // The extra pointer MSB is a wrap bit telling full apart from empty.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign count_o = wptr_q - rptr_q;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer/storage update; clear wins over push and pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        mem_d  = mem_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i && !full_o) begin
                mem_d[wptr_q[AW-1:0]] = wdata_i;
                wptr_d = wptr_q + PTR_W'(1);
            end
            if (pop_i && !empty_o) begin
                rptr_d = rptr_q + PTR_W'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Record storage; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/puc_train_unit.sv
// Compares resolved uncache attributes with predictions; trains the predictor and requests refetch.
module puc_train_unit
    import puc_train_unit_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDX_LSB    = 12,
    parameter int unsigned IDX_W      = PucAddrWidth,
    parameter int unsigned CNT_W      = 32
) (
    input logic          clk,
    input logic          rst_n,
    puc_train_unit_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENT_W = 33;

    logic [0:0]       state_q, state_d;
    logic             req_ready_q, req_ready_d;
    logic             rsp_ready_q, rsp_ready_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [31:0]      redirect_pc_q, redirect_pc_d;
    logic [IDX_W+1:0] wbus_q, wbus_d;
    logic [CNT_W-1:0] resolve_q, resolve_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;

    logic             push, pop, clr;
    logic [PTR_W-1:0] cnt_next;
    logic [ENT_W-1:0] fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic [PTR_W-1:0] fifo_count;
    logic [31:0]      head_pc;
    logic             head_pred;

    assign head_pc   = fifo_rdata[ENT_W-1:1];
    assign head_pred = fifo_rdata[0];

    puc_inflight_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({bus.req_pc_i, bus.req_pred_uc_i}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next state, compare, training pulse, counters and next-cycle ready flags.
    always_comb begin
        state_d       = state_q;
        redirect_pc_d = redirect_pc_q;
        wbus_d        = '0;
        resolve_d     = resolve_q;
        mispred_d     = mispred_q;
        clr           = 1'b0;

        // Flush suppresses any handshake in the same cycle.
        push = bus.req_valid_i && req_ready_q && !fifo_full && !bus.flush_i;
        pop  = bus.rsp_valid_i && rsp_ready_q && !fifo_empty && !bus.flush_i;

        if (bus.flush_i) begin
            state_d = IDLE;
            clr     = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop && (bus.rsp_uc_i != head_pred)) begin
                        state_d       = REDIRECT;
                        redirect_pc_d = head_pc;
                        wbus_d        = {1'b1, head_pc[IDX_LSB +: IDX_W], bus.rsp_uc_i};
                        if (mispred_q != '1) begin
                            mispred_d = mispred_q + CNT_W'(1);
                        end
                    end
                end
                REDIRECT: begin
                    // Every younger record is wrong-path once the refetch is taken.
                    if (bus.redirect_ack_i) begin
                        state_d = IDLE;
                        clr     = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (pop && (resolve_q != '1)) begin
            resolve_d = resolve_q + CNT_W'(1);
        end

        cnt_next         = clr ? '0 : (fifo_count + PTR_W'(push) - PTR_W'(pop));
        req_ready_d      = (state_d == IDLE) && (cnt_next != PTR_W'(FIFO_DEPTH));
        rsp_ready_d      = (state_d == IDLE) && (cnt_next != '0);
        redirect_valid_d = (state_d == REDIRECT);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst_n == RstEnable) begin
            state_q          <= IDLE;
            req_ready_q      <= 1'b1;
            rsp_ready_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            wbus_q           <= '0;
            resolve_q        <= '0;
            mispred_q        <= '0;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            rsp_ready_q      <= rsp_ready_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            wbus_q           <= wbus_d;
            resolve_q        <= resolve_d;
            mispred_q        <= mispred_d;
        end
    end

    assign bus.req_ready_o      = req_ready_q;
    assign bus.rsp_ready_o      = rsp_ready_q;
    assign bus.redirect_valid_o = redirect_valid_q;
    assign bus.redirect_pc_o    = redirect_pc_q;
    assign bus.puc_wbus_o       = wbus_q;
    assign bus.resolve_cnt_o    = resolve_q;
    assign bus.mispred_cnt_o    = mispred_q;
endmodule

// File: tb/tb_puc_train_unit.sv
// Bench: a 32-bit-counter unit and a 2-bit-counter unit share one stimulus stream; both are checked every cycle against a queue-based model.
module tb_puc_train_unit;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned IDX_LSB = 12;
    localparam int unsigned IDX_W   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    puc_train_unit_if #(.IDX_W(IDX_W), .CNT_W(32)) if0 ();
    puc_train_unit_if #(.IDX_W(IDX_W), .CNT_W(2))  if1 ();

    assign if1.req_valid_i    = if0.req_valid_i;
    assign if1.req_pc_i       = if0.req_pc_i;
    assign if1.req_pred_uc_i  = if0.req_pred_uc_i;
    assign if1.rsp_valid_i    = if0.rsp_valid_i;
    assign if1.rsp_uc_i       = if0.rsp_uc_i;
    assign if1.flush_i        = if0.flush_i;
    assign if1.redirect_ack_i = if0.redirect_ack_i;

    puc_train_unit #(.FIFO_DEPTH(DEPTH), .IDX_LSB(IDX_LSB), .IDX_W(IDX_W), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    puc_train_unit #(.FIFO_DEPTH(DEPTH), .IDX_LSB(IDX_LSB), .IDX_W(IDX_W), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } rec_t;

    rec_t         q[$];
    bit           m_redir;
    logic [31:0]  m_rpc;
    logic [6:0]   m_wbus;
    longint       m_resolve, m_mispred;
    int           tests, fails, pulses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_redir = 1'b0; m_rpc = '0; m_wbus = '0;
        m_resolve = 0; m_mispred = 0;
    endtask

    task automatic drive(input logic rv, input logic [31:0] pc, input logic pred,
                         input logic sv, input logic uc, input logic fl, input logic ack);
        if0.req_valid_i = rv; if0.req_pc_i = pc; if0.req_pred_uc_i = pred;
        if0.rsp_valid_i = sv; if0.rsp_uc_i = uc;
        if0.flush_i = fl; if0.redirect_ack_i = ack;
    endtask

    // Compare current outputs with the model, advance the model by this cycle's inputs, then clock.
    task automatic step();
        rec_t r;
        bit   push_ok;
        int   sz;
        longint sat_res, sat_mis;
        sat_res = (m_resolve > 3) ? 3 : m_resolve;
        sat_mis = (m_mispred > 3) ? 3 : m_mispred;
        chk("req_ready", 64'(if0.req_ready_o), 64'(!m_redir && q.size() < DEPTH));
        chk("rsp_ready", 64'(if0.rsp_ready_o), 64'(!m_redir && q.size() > 0));
        chk("wbus", 64'(if0.puc_wbus_o), 64'(m_wbus));
        chk("redirect_valid", 64'(if0.redirect_valid_o), 64'(m_redir));
        if (m_redir) chk("redirect_pc", 64'(if0.redirect_pc_o), 64'(m_rpc));
        chk("resolve_cnt", 64'(if0.resolve_cnt_o), 64'(m_resolve));
        chk("mispred_cnt", 64'(if0.mispred_cnt_o), 64'(m_mispred));
        chk("resolve_cnt_sat", 64'(if1.resolve_cnt_o), 64'(sat_res));
        chk("mispred_cnt_sat", 64'(if1.mispred_cnt_o), 64'(sat_mis));
        if (if0.puc_wbus_o[IDX_W+1]) pulses++;

        if (!rst_n) begin
            model_reset();
        end else begin
            m_wbus = '0;
            if (if0.flush_i) begin
                q.delete();
                m_redir = 1'b0;
            end else if (m_redir) begin
                if (if0.redirect_ack_i) begin
                    q.delete();
                    m_redir = 1'b0;
                end
            end else begin
                sz = q.size();
                push_ok = if0.req_valid_i && (sz < DEPTH);
                if (if0.rsp_valid_i && sz > 0) begin
                    r = q.pop_front();
                    m_resolve++;
                    if (if0.rsp_uc_i != r.pred) begin
                        m_mispred++;
                        m_wbus  = {1'b1, r.pc[IDX_LSB +: IDX_W], if0.rsp_uc_i};
                        m_redir = 1'b1;
                        m_rpc   = r.pc;
                    end
                end
                if (push_ok) q.push_back('{pc: if0.req_pc_i, pred: if0.req_pred_uc_i});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
        end
    endtask

    initial begin
        logic [6:0] exp_wbus;
        tests = 0; fails = 0; pulses = 0;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // Reset values.
        chk("rst_req_ready", 64'(if0.req_ready_o), 64'(1));
        chk("rst_rsp_ready", 64'(if0.rsp_ready_o), 64'(0));
        chk("rst_wbus", 64'(if0.puc_wbus_o), 64'(0));
        step();

        // Matching prediction: resolved, no training.
        drive(1'b1, 32'h1C00_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step();
        chk("match_resolve", 64'(if0.resolve_cnt_o), 64'(1));
        chk("match_mispred", 64'(if0.mispred_cnt_o), 64'(0));
        idle_steps(1);

        // Mismatch with two younger records, ack at T+3.
        drive(1'b1, 32'h0000_5000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h0000_6000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h0000_7000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
        exp_wbus = 7'b1_00101_0;
        chk("mis_wbus", 64'(if0.puc_wbus_o), 64'(exp_wbus));
        chk("mis_redirect_pc", 64'(if0.redirect_pc_o), 64'(32'h0000_5000));
        idle_steps(2);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        chk("ack_redirect_valid", 64'(if0.redirect_valid_o), 64'(0));
        chk("ack_fifo_empty", 64'(if0.rsp_ready_o), 64'(0));
        idle_steps(1);

        // Fill the FIFO; fifth PC is held until space opens.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h0001_0000 + 32'(i) * 32'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        end
        drive(1'b1, 32'h0002_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        chk("full_req_ready", 64'(if0.req_ready_o), 64'(0));
        drive(1'b1, 32'h0002_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
        chk("after_pop_req_ready", 64'(if0.req_ready_o), 64'(1));
        drive(1'b1, 32'h0002_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
        end
        idle_steps(1);

        // Mismatch then flush with no ack.
        pulses = 0;
        drive(1'b1, 32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b1, 32'h0000_4000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); step();
        idle_steps(1);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0); step();
        chk("flush_redirect_valid", 64'(if0.redirect_valid_o), 64'(0));
        chk("flush_fifo_empty", 64'(if0.rsp_ready_o), 64'(0));
        idle_steps(2);
        chk("flush_pulses", 64'(pulses), 64'(1));

        // Five acked mismatches drive the narrow counter into saturation.
        for (int i = 0; i < 5; i++) begin
            logic p;
            p = 1'(i);
            drive(1'b1, 32'h0008_0000 + 32'(i) * 32'h1000, p, 1'b0, 1'b0, 1'b0, 1'b0); step();
            drive(1'b0, '0, 1'b0, 1'b1, ~p, 1'b0, 1'b0); step();
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); step();
        end
        idle_steps(1);
        chk("sat_mispred", 64'(if1.mispred_cnt_o), 64'(3));

        // Reset while a redirect is pending.
        drive(1'b1, 32'h0000_9000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); step();
        drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); step();
        rst_n = 1'b0;
        idle_steps(1);
        rst_n = 1'b1;
        chk("rst_mid_wbus", 64'(if0.puc_wbus_o), 64'(0));
        chk("rst_mid_redirect", 64'(if0.redirect_valid_o), 64'(0));
        chk("rst_mid_req_ready", 64'(if0.req_ready_o), 64'(1));
        idle_steps(1);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0));
            step();
        end
        idle_steps(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
